// File: rtl/product_bcd_converter.sv
// Sequential binary-to-BCD converter (double dabble, one bit per clock).
// Sits between the multiplier product register and the per-digit
// seven-segment decoders; 4'hF on a digit means "blank" downstream.
module product_bcd_converter #(
  parameter int WIDTH    = 8,
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] bin_in,
  output logic             busy,
  output logic             done,
  output logic [3:0]       bcd_hundreds,
  output logic [3:0]       bcd_tens,
  output logic [3:0]       bcd_ones
);

  typedef enum logic [1:0] {IDLE, SHIFT, FINISH} state_t;

  // Idle display value "0": leading digits blank when blanking is enabled
  localparam logic [3:0] LEAD_RST = BLANK_LZ ? 4'hF : 4'h0;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   shift_q, shift_d;
  logic [11:0]        scratch_q, scratch_d;
  logic [3:0]         cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [3:0]         hund_q, hund_d;
  logic [3:0]         tens_q, tens_d;
  logic [3:0]         ones_q, ones_d;
  logic [11:0]        adj;
  logic               hund_blank, tens_blank;

  // Add-3 correction on every BCD nibble that is >= 5, before the shift
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_adj
      always_comb begin
        adj[gi*4 +: 4] = (scratch_q[gi*4 +: 4] >= 4'd5) ?
                         scratch_q[gi*4 +: 4] + 4'd3 : scratch_q[gi*4 +: 4];
      end
    end
  endgenerate

  // Leading-zero blanking: tens only blanks when hundreds is blank too
  always_comb begin
    hund_blank = BLANK_LZ && (scratch_q[11:8] == 4'd0);
    tens_blank = hund_blank && (scratch_q[7:4] == 4'd0);
  end

  // Next-state and datapath control
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    scratch_d = scratch_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    hund_d    = hund_q;
    tens_d    = tens_q;
    ones_d    = ones_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          shift_d   = bin_in;
          scratch_d = 12'd0;
          cnt_d     = 4'(WIDTH);
          busy_d    = 1'b1;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        // The top scratch bit is always zero here since values fit in 3 digits
        {scratch_d, shift_d} = {adj[10:0], shift_q, 1'b0};
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = FINISH;
      end
      FINISH: begin
        hund_d  = hund_blank ? 4'hF : scratch_q[11:8];
        tens_d  = tens_blank ? 4'hF : scratch_q[7:4];
        ones_d  = scratch_q[3:0];
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      scratch_q <= 12'd0;
      cnt_q     <= 4'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      hund_q    <= LEAD_RST;
      tens_q    <= LEAD_RST;
      ones_q    <= 4'h0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      scratch_q <= scratch_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      hund_q    <= hund_d;
      tens_q    <= tens_d;
      ones_q    <= ones_d;
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign bcd_hundreds = hund_q;
  assign bcd_tens     = tens_q;
  assign bcd_ones     = ones_q;

endmodule

// File: tb/tb_product_bcd_converter.sv
// Directed bench for product_bcd_converter: one instance with leading-zero
// blanking, one without, driven from the same stimulus.
module tb_product_bcd_converter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] bin_in;
  logic       busy_b, done_b, busy_n, done_n;
  logic [3:0] h_b, t_b, o_b, h_n, t_n, o_n;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  product_bcd_converter #(.WIDTH(8), .BLANK_LZ(1'b1)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start), .bin_in(bin_in),
    .busy(busy_b), .done(done_b),
    .bcd_hundreds(h_b), .bcd_tens(t_b), .bcd_ones(o_b)
  );

  product_bcd_converter #(.WIDTH(8), .BLANK_LZ(1'b0)) u_n (
    .clk(clk), .rst_n(rst_n), .start(start), .bin_in(bin_in),
    .busy(busy_n), .done(done_n),
    .bcd_hundreds(h_n), .bcd_tens(t_n), .bcd_ones(o_n)
  );

  typedef struct {
    logic [7:0]  bin;
    logic [11:0] exp_b;   // {hundreds, tens, ones} with blanking
    logic [11:0] exp_n;   // {hundreds, tens, ones} without blanking
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference built from division, independent of the shift algorithm
  function automatic logic [11:0] ref_digits(input int v, input bit blank);
    logic [3:0] h, t, o;
    h = 4'(v / 100);
    t = 4'((v / 10) % 10);
    o = 4'(v % 10);
    if (blank && h == 4'd0) begin
      h = 4'hF;
      if (t == 4'd0) t = 4'hF;
    end
    return {h, t, o};
  endfunction

  // Called at a negedge; returns at the negedge where done is seen.
  // lat = edges after the start edge; -1 on timeout.
  task automatic run_conv(input logic [7:0] v, output int lat, output bit busy_ok);
    start  = 1'b1;
    bin_in = v;
    @(posedge clk);
    @(negedge clk);
    start   = 1'b0;
    lat     = 0;
    busy_ok = 1'b1;
    while (!done_b && lat < 30) begin
      busy_ok = busy_ok & busy_b;
      @(negedge clk);
      lat++;
    end
    if (!done_b) begin
      lat = -1;
      chk("done_timeout", 32'd0, 32'd1);
    end
  endtask

  initial begin
    int  lat;
    bit  bok;
    int  dcnt;
    int  last;
    int  got;
    logic [11:0] dig;

    vecs[0] = '{8'd0,   12'hFF0, 12'h000};
    vecs[1] = '{8'd9,   12'hFF9, 12'h009};
    vecs[2] = '{8'd100, 12'h100, 12'h100};
    vecs[3] = '{8'd105, 12'h105, 12'h105};
    vecs[4] = '{8'd225, 12'h225, 12'h225};
    vecs[5] = '{8'd10,  12'hF10, 12'h010};
    vecs[6] = '{8'd99,  12'hF99, 12'h099};
    vecs[7] = '{8'd200, 12'h200, 12'h200};
    vecs[8] = '{8'd42,  12'hF42, 12'h042};
    vecs[9] = '{8'd1,   12'hFF1, 12'h001};

    // Reset
    rst_n = 1'b0; start = 1'b0; bin_in = 8'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_busy", {31'd0, busy_b}, 32'd0);
    chk("rst_done", {31'd0, done_b}, 32'd0);
    chk("rst_digits_b", {20'd0, h_b, t_b, o_b}, 32'hFF0);
    chk("rst_digits_n", {20'd0, h_n, t_n, o_n}, 32'h000);
    $display("reset released: busy=%0b done=%0b digits=%h%h%h", busy_b, done_b, h_b, t_b, o_b);

    // Vector table
    for (int i = 0; i < 10; i++) begin
      run_conv(vecs[i].bin, lat, bok);
      $display("conv %0d: lat=%0d digits_b=%h%h%h digits_n=%h%h%h",
               vecs[i].bin, lat, h_b, t_b, o_b, h_n, t_n, o_n);
      chk("latency", lat, 9);
      chk("busy_during", {31'd0, bok}, 32'd1);
      chk("busy_at_done", {31'd0, busy_b}, 32'd0);
      chk("digits_b", {20'd0, h_b, t_b, o_b}, {20'd0, vecs[i].exp_b});
      chk("digits_n", {20'd0, h_n, t_n, o_n}, {20'd0, vecs[i].exp_n});
      chk("done_n", {31'd0, done_n}, 32'd1);
      @(negedge clk);
      chk("done_pulse_width", {31'd0, done_b}, 32'd0);
    end

    // start mid-conversion is ignored; digits hold old result (FF1 from 1)
    start = 1'b1; bin_in = 8'd225;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    dcnt = 0; got = -1; dig = 12'h000;
    for (int c = 0; c < 20; c++) begin
      if (c == 3) begin start = 1'b1; bin_in = 8'd42; end
      if (c == 4) start = 1'b0;
      if (c == 5) chk("hold_prior", {20'd0, h_b, t_b, o_b}, 32'hFF1);
      if (done_b) begin
        dcnt++;
        if (got < 0) begin got = c; dig = {h_b, t_b, o_b}; end
      end
      @(negedge clk);
    end
    $display("ignore-start: dones=%0d at=%0d digits=%h", dcnt, got, dig);
    chk("ignore_done_count", dcnt, 1);
    chk("ignore_done_at", got, 9);
    chk("ignore_digits", {20'd0, dig}, 32'h225);

    // Reset mid-conversion of 144
    start = 1'b1; bin_in = 8'd144;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    $display("abort: busy=%0b done=%0b digits=%h%h%h", busy_b, done_b, h_b, t_b, o_b);
    chk("abort_busy", {31'd0, busy_b}, 32'd0);
    chk("abort_digits_b", {20'd0, h_b, t_b, o_b}, 32'hFF0);
    chk("abort_digits_n", {20'd0, h_n, t_n, o_n}, 32'h000);
    rst_n = 1'b1;
    dcnt = 0;
    for (int c = 0; c < 15; c++) begin
      if (done_b || done_n) dcnt++;
      @(negedge clk);
    end
    chk("abort_no_done", dcnt, 0);

    // start held high: back-to-back with bin_in stepping 1,2,3
    start = 1'b1; bin_in = 8'd1;
    @(posedge clk);
    @(negedge clk);
    dcnt = 0; last = 0;
    for (int c = 0; c < 40 && dcnt < 3; c++) begin
      if (done_b) begin
        dcnt++;
        $display("b2b %0d: cycle=%0d digits=%h%h%h", dcnt, c, h_b, t_b, o_b);
        chk("b2b_digits", {20'd0, h_b, t_b, o_b}, {20'd0, 8'hFF, 4'(dcnt)});
        chk("b2b_timing", c, (dcnt == 1) ? 9 : last + 10);
        last = c;
        bin_in = 8'(dcnt + 1);
        if (dcnt == 3) start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    chk("b2b_count", dcnt, 3);
    repeat (12) @(negedge clk);

    // Sweep 0..225 against the division-based model
    for (int v = 0; v <= 225; v++) begin
      run_conv(8'(v), lat, bok);
      $display("sweep %0d: digits_b=%h%h%h digits_n=%h%h%h", v, h_b, t_b, o_b, h_n, t_n, o_n);
      chk("sweep_b", {20'd0, h_b, t_b, o_b}, {20'd0, ref_digits(v, 1'b1)});
      chk("sweep_n", {20'd0, h_n, t_n, o_n}, {20'd0, ref_digits(v, 1'b0)});
      @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
